// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES key-schedule definitions: PC-1 / PC-2 selection tables, the
// per-round shift schedules for both directions, datapath widths, the
// scheduler FSM state type and the key byte parity helper.
// Table entries use DES bit numbering: bit 1 is the most significant bit of
// the source vector.
// -----------------------------------------------------------------------------
package des_pkg;

   localparam int C_W      = 28;
   localparam int CD_W     = 2 * C_W;
   localparam int SUBKEY_W = 48;
   localparam int ROUND_W  = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sched_state_t;

   // PC-1: 64-bit key (parity bits dropped) -> 56-bit {C, D}
   localparam logic [5:0] PC1 [0:55] = '{
      6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
      6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
      6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
      6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
      6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
      6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
      6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
      6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
   };

   // PC-2: 56-bit {C, D} -> 48-bit subkey
   localparam logic [5:0] PC2 [0:47] = '{
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
      6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
      6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
      6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
      6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
      6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
      6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
   };

   // Left-rotate amounts for encrypt rounds 1..16 (sum = 28)
   localparam logic [1:0] ENC_SHIFT [0:15] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   // Right-rotate amounts for decrypt rounds 1..16; round 1 uses PC-1 as-is
   localparam logic [1:0] DEC_SHIFT [0:15] = '{
      2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   // Per-byte odd-parity failure flags; bit b is 1 when key byte b has even parity
   function automatic logic [7:0] key_parity_err(input logic [63:0] key);
      logic [7:0] err;
      err = 8'h00;
      for (int b = 0; b < 8; b++) begin
         err[b] = ~^key[8*b +: 8];
      end
      return err;
   endfunction

endpackage

// File: rtl/des_key_sched_checker.sv
// -----------------------------------------------------------------------------
// des_key_sched_checker
// Simulation-only properties for des_key_scheduler. Holds the PC-1 value of
// the accepted key and checks that the encrypt rotations wrap back to it at
// round 16, and that a valid subkey always carries a round index of 1..16.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   i_accept         key accepted this cycle
//   i_dec            latched direction (1 = decrypt)
//   i_subkey_valid   subkey output valid
//   i_pc1            PC-1 of the key currently on key_in
//   i_cd             registered {C, D}
//   i_round          registered round index
// -----------------------------------------------------------------------------
module des_key_sched_checker
   import des_pkg::*;
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               i_accept,
   input  logic               i_dec,
   input  logic               i_subkey_valid,
   input  logic [CD_W-1:0]    i_pc1,
   input  logic [CD_W-1:0]    i_cd,
   input  logic [ROUND_W-1:0] i_round
);

   logic [CD_W-1:0] r_pc1_ref;

   // Capture PC-1 of the accepted key as the wrap-around reference
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pc1_ref <= '0;
      end else if (i_accept) begin
         r_pc1_ref <= i_pc1;
      end else begin
         r_pc1_ref <= r_pc1_ref;
      end
   end

   a_enc_wrap: assert property (@(posedge clock) disable iff (!reset_n)
      (i_subkey_valid && !i_dec && (i_round == 5'd16)) |-> (i_cd == r_pc1_ref));

   a_round_range: assert property (@(posedge clock) disable iff (!reset_n)
      i_subkey_valid |-> ((i_round >= 5'd1) && (i_round <= 5'd16)));

endmodule

// File: rtl/des_pc2_perm.sv
// -----------------------------------------------------------------------------
// des_pc2_perm
// Combinational PC-2 compression of the 56-bit {C, D} state to a 48-bit
// round subkey. Pure wiring; shared with the round engine's checker.
// Ports:
//   i_cd      in  56  {C, D}; i_cd[55] is DES bit 1
//   o_subkey  out 48  subkey; o_subkey[47] is PC-2 bit 1
// -----------------------------------------------------------------------------
module des_pc2_perm
   import des_pkg::*;
(
   input  logic [CD_W-1:0]     i_cd,
   output logic [SUBKEY_W-1:0] o_subkey
);

   // Select each subkey bit from its PC-2 source position (MSB-first numbering)
   always_comb begin
      o_subkey = '0;
      for (int i = 0; i < SUBKEY_W; i++) begin
         o_subkey[SUBKEY_W-1-i] = i_cd[CD_W - int'(PC2[i])];
      end
   end

endmodule

// File: rtl/des_key_scheduler.sv
// -----------------------------------------------------------------------------
// des_key_scheduler
// Iterative DES key schedule: one 48-bit subkey per consumer handshake, in
// encrypt order (K1..K16) or decrypt order (K16..K1), using only the two
// 28-bit C/D rotating registers.
// Optional feature macro: DES_KEY_PARITY_CHECK_EN (per-byte odd-parity flags
// captured on key acceptance; tied to zero when undefined).
// Ports:
//   clock         in   1   rising-edge clock
//   reset_n       in   1   asynchronous active-low reset
//   key_in        in   64  key; key_in[63] is DES bit 1
//   decrypt       in   1   direction, sampled with the key
//   key_valid     in   1   key offered
//   key_ready     out  1   high only in IDLE
//   subkey_out    out  48  current subkey; subkey_out[47] is PC-2 bit 1
//   subkey_valid  out  1   subkey_out / round_idx valid
//   subkey_ready  in   1   consumer takes the subkey
//   round_idx     out  5   issue order 1..16
//   sched_done    out  1   one-cycle pulse after the 16th subkey is taken
//   parity_err    out  8   per-byte parity failure; bit 7 = DES bits 1-8
// -----------------------------------------------------------------------------
module des_key_scheduler
   import des_pkg::*;
#(
   parameter int ROUNDS   = 16,
   parameter int KEY_W    = 64,
   parameter int SUBKEY_W = 48
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [KEY_W-1:0]    key_in,
   input  logic                decrypt,
   input  logic                key_valid,
   output logic                key_ready,
   output logic [SUBKEY_W-1:0] subkey_out,
   output logic                subkey_valid,
   input  logic                subkey_ready,
   output logic [ROUND_W-1:0]  round_idx,
   output logic                sched_done,
   output logic [7:0]          parity_err
);

   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS);

   sched_state_t        r_state;
   sched_state_t        w_state_nxt;
   logic                w_accept;
   logic                w_advance;
   logic [CD_W-1:0]     w_pc1;
   logic [C_W-1:0]      r_c;
   logic [C_W-1:0]      r_d;
   logic [C_W-1:0]      w_c_src;
   logic [C_W-1:0]      w_d_src;
   logic [C_W-1:0]      w_c_nxt;
   logic [C_W-1:0]      w_d_nxt;
   logic                r_dec;
   logic                w_dir_dec;
   logic [ROUND_W-1:0]  r_round;
   logic [ROUND_W-1:0]  w_round_nxt;
   logic [3:0]          w_sh_idx;
   logic [1:0]          w_shift;
   logic [SUBKEY_W-1:0] r_subkey;
   logic [SUBKEY_W-1:0] w_subkey;
   logic                r_key_ready;
   logic                r_subkey_valid;
   logic                r_sched_done;

   // PC-1 selection of the offered key into {C, D}
   always_comb begin
      w_pc1 = '0;
      for (int i = 0; i < CD_W; i++) begin
         w_pc1[CD_W-1-i] = key_in[KEY_W - int'(PC1[i])];
      end
   end

   // Next-state and handshake decode
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_advance   = 1'b0;
      case (r_state)
         IDLE: begin
            if (key_valid && r_key_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            if (r_subkey_valid && subkey_ready) begin
               if (r_round == LAST_ROUND) begin
                  w_state_nxt = DONE;
               end else begin
                  w_advance   = 1'b1;
                  w_state_nxt = RUN;
               end
            end else begin
               w_state_nxt = RUN;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Rotation source: fresh PC-1 on acceptance, otherwise the held C/D
   always_comb begin
      if (w_accept) begin
         w_c_src     = w_pc1[CD_W-1:C_W];
         w_d_src     = w_pc1[C_W-1:0];
         w_dir_dec   = decrypt;
         w_round_nxt = 5'd1;
      end else begin
         w_c_src     = r_c;
         w_d_src     = r_d;
         w_dir_dec   = r_dec;
         w_round_nxt = r_round + 5'd1;
      end
   end

   // Round 16 wraps to index 15 through the 4-bit subtraction
   assign w_sh_idx = w_round_nxt[3:0] - 4'd1;
   assign w_shift  = w_dir_dec ? DEC_SHIFT[w_sh_idx] : ENC_SHIFT[w_sh_idx];

   // C/D rotation: left for encrypt, right for decrypt, by 0, 1 or 2
   always_comb begin
      case ({w_dir_dec, w_shift})
         3'b0_01: begin
            w_c_nxt = {w_c_src[C_W-2:0], w_c_src[C_W-1]};
            w_d_nxt = {w_d_src[C_W-2:0], w_d_src[C_W-1]};
         end
         3'b0_10: begin
            w_c_nxt = {w_c_src[C_W-3:0], w_c_src[C_W-1:C_W-2]};
            w_d_nxt = {w_d_src[C_W-3:0], w_d_src[C_W-1:C_W-2]};
         end
         3'b1_01: begin
            w_c_nxt = {w_c_src[0], w_c_src[C_W-1:1]};
            w_d_nxt = {w_d_src[0], w_d_src[C_W-1:1]};
         end
         3'b1_10: begin
            w_c_nxt = {w_c_src[1:0], w_c_src[C_W-1:2]};
            w_d_nxt = {w_d_src[1:0], w_d_src[C_W-1:2]};
         end
         default: begin
            w_c_nxt = w_c_src;
            w_d_nxt = w_d_src;
         end
      endcase
   end

   des_pc2_perm u_pc2 (
      .i_cd     ({w_c_nxt, w_d_nxt}),
      .o_subkey (w_subkey)
   );

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Handshake/status outputs registered from the next state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_key_ready    <= 1'b1;
         r_subkey_valid <= 1'b0;
         r_sched_done   <= 1'b0;
      end else begin
         r_key_ready    <= (w_state_nxt == IDLE);
         r_subkey_valid <= (w_state_nxt == RUN);
         r_sched_done   <= (w_state_nxt == DONE);
      end
   end

   // C/D, subkey and round counter move only on accept or advance
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_c      <= '0;
         r_d      <= '0;
         r_subkey <= '0;
         r_round  <= '0;
         r_dec    <= 1'b0;
      end else begin
         if (w_accept || w_advance) begin
            r_c      <= w_c_nxt;
            r_d      <= w_d_nxt;
            r_subkey <= w_subkey;
            r_round  <= w_round_nxt;
         end else begin
            r_c      <= r_c;
            r_d      <= r_d;
            r_subkey <= r_subkey;
            r_round  <= r_round;
         end
         if (w_accept) begin
            r_dec <= decrypt;
         end else begin
            r_dec <= r_dec;
         end
      end
   end

`ifdef DES_KEY_PARITY_CHECK_EN
   logic [7:0] r_parity_err;

   // Parity flags captured on acceptance, held until the next key
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_parity_err <= 8'h00;
      end else if (w_accept) begin
         r_parity_err <= key_parity_err(key_in[63:0]);
      end else begin
         r_parity_err <= r_parity_err;
      end
   end

   assign parity_err = r_parity_err;
`else
   // Parity bits of the key are not used by the schedule itself
   logic w_unused_key_bits;
   assign w_unused_key_bits = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                                key_in[24], key_in[16], key_in[8],  key_in[0]};
   assign parity_err = 8'h00;
`endif

   assign key_ready    = r_key_ready;
   assign subkey_out   = r_subkey;
   assign subkey_valid = r_subkey_valid;
   assign round_idx    = r_round;
   assign sched_done   = r_sched_done;

   des_key_sched_checker u_chk (
      .clock          (clock),
      .reset_n        (reset_n),
      .i_accept       (w_accept),
      .i_dec          (r_dec),
      .i_subkey_valid (r_subkey_valid),
      .i_pc1          (w_pc1),
      .i_cd           ({r_c, r_d}),
      .i_round        (r_round)
   );

endmodule

// File: tb/tb_des_key_scheduler.sv
// -----------------------------------------------------------------------------
// tb_des_key_scheduler
// Self-checking bench: known-answer table, random keys against an index-based
// reference key schedule, backpressure, mid-run reset, key_valid during RUN,
// key held from DONE, and key parity flags (DES_KEY_PARITY_CHECK_EN aware).
// -----------------------------------------------------------------------------
module tb_des_key_scheduler;

   logic        clock;
   logic        reset_n;
   logic [63:0] key_in;
   logic        decrypt;
   logic        key_valid;
   logic        key_ready;
   logic [47:0] subkey_out;
   logic        subkey_valid;
   logic        subkey_ready;
   logic [4:0]  round_idx;
   logic        sched_done;
   logic [7:0]  parity_err;

   int n_checks = 0;
   int n_errors = 0;

   logic [47:0] cap_key [16];

   int PC1_M [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                      10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                      63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                      14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   int PC2_M [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                      23,19,12,4,26,8, 16,7,27,20,13,2,
                      41,52,31,37,47,55, 30,40,51,45,33,48,
                      44,49,39,56,34,53, 46,42,50,36,29,32};
   int SH_M  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   typedef struct {
      logic [63:0] key;
      logic        dec;
      int          round;
      logic [47:0] exp;
   } kat_t;

   kat_t kat [5];

   des_key_scheduler dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .key_in       (key_in),
      .decrypt      (decrypt),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .subkey_out   (subkey_out),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .round_idx    (round_idx),
      .sched_done   (sched_done),
      .parity_err   (parity_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // DES key number knum (1..16): cumulative left shift applied by index arithmetic
   function automatic logic [47:0] model_subkey(input logic [63:0] k, input int knum);
      logic [47:0] r;
      int s, p, half, j, src, desbit;
      s = 0;
      for (int i = 0; i < knum; i++) s += SH_M[i];
      r = '0;
      for (int i = 0; i < 48; i++) begin
         p      = PC2_M[i];
         half   = (p > 28) ? 1 : 0;
         j      = p - 1 - 28 * half;
         src    = (j + s) % 28;
         desbit = PC1_M[28 * half + src];
         r[47-i] = k[64 - desbit];
      end
      return r;
   endfunction

   function automatic logic [47:0] model_issue(input logic [63:0] k, input logic dec, input int n);
      return model_subkey(k, dec ? (17 - n) : n);
   endfunction

   function automatic logic [7:0] par_model(input logic [63:0] k);
      logic [7:0] r;
      int ones;
      r = 8'h00;
`ifdef DES_KEY_PARITY_CHECK_EN
      for (int b = 0; b < 8; b++) begin
         ones = 0;
         for (int t = 0; t < 8; t++) ones += int'(k[8*b+t]);
         r[b] = ((ones % 2) == 0);
      end
`else
      ones = 0;
`endif
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic start_key(input logic [63:0] key, input logic dec);
      int c;
      c = 0;
      while (!key_ready && c < 50) begin
         @(posedge clock); #1; c++;
      end
      chk("key_ready before offer", key_ready, 1);
      key_in = key; decrypt = dec; key_valid = 1'b1; subkey_ready = 1'b1;
      @(posedge clock); #1;
      key_valid = 1'b0;
      key_in    = {$urandom, $urandom};
      decrypt   = ~dec;
      chk("first subkey valid latency", subkey_valid, 1);
      chk("first round_idx", round_idx, 1);
      chk("key_ready low in RUN", key_ready, 0);
      chk("parity_err", parity_err, par_model(key));
   endtask

   // Runs from the first valid subkey to the DONE cycle, checking every round
   task automatic collect(input logic [63:0] key, input logic dec, input int stall_at,
                          input int stall_n, input int inject_at);
      int got, cyc, stalls;
      bit injected;
      got = 0; cyc = 0; stalls = 0; injected = 1'b0;
      while (got < 16 && cyc < 100) begin
         key_valid = 1'b0;
         if (subkey_valid) begin
            if (round_idx == stall_at && stalls < stall_n) begin
               subkey_ready = 1'b0;
               chk("stall round_idx hold", round_idx, stall_at);
               chk("stall subkey hold", subkey_out, model_issue(key, dec, stall_at));
               stalls++;
            end else begin
               subkey_ready = 1'b1;
               if (!injected && (got + 1) == inject_at) begin
                  key_valid = 1'b1; key_in = ~key; decrypt = ~dec; injected = 1'b1;
               end
               chk($sformatf("round_idx seq %0d", got + 1), round_idx, got + 1);
               chk($sformatf("subkey round %0d", got + 1), subkey_out, model_issue(key, dec, got + 1));
               cap_key[got] = subkey_out;
               got++;
            end
         end else begin
            subkey_ready = 1'b1;
         end
         @(posedge clock); #1; cyc++;
      end
      key_valid = 1'b0;
      chk("subkeys delivered", got, 16);
      chk("sched_done pulse", sched_done, 1);
      chk("key_ready low in DONE", key_ready, 0);
      chk("subkey_valid low in DONE", subkey_valid, 0);
      chk("cycles first valid to done", cyc, 16 + stalls);
   endtask

   task automatic post_done();
      @(posedge clock); #1;
      chk("sched_done one cycle", sched_done, 0);
      chk("key_ready after done", key_ready, 1);
      chk("subkey_valid idle", subkey_valid, 0);
   endtask

   initial begin
      logic [63:0] rk;
      logic        rd;
      int          c;

      kat[0] = '{64'h133457799BBCDFF1, 1'b0, 1,  48'h1B02EFFC7072};
      kat[1] = '{64'h133457799BBCDFF1, 1'b0, 2,  48'h79AED9DBC9E5};
      kat[2] = '{64'h133457799BBCDFF1, 1'b0, 16, 48'hCB3D8B0E17F5};
      kat[3] = '{64'h133457799BBCDFF1, 1'b1, 1,  48'hCB3D8B0E17F5};
      kat[4] = '{64'h133457799BBCDFF1, 1'b1, 16, 48'h1B02EFFC7072};

      reset_n = 1'b0; key_in = 64'h0; decrypt = 1'b0; key_valid = 1'b0; subkey_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset key_ready", key_ready, 1);
      chk("reset subkey_valid", subkey_valid, 0);
      chk("reset subkey_out", subkey_out, 0);
      chk("reset round_idx", round_idx, 0);
      chk("reset sched_done", sched_done, 0);
      chk("reset parity_err", parity_err, 0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // Known-answer table
      for (int i = 0; i < 5; i++) begin
         start_key(kat[i].key, kat[i].dec);
         collect(kat[i].key, kat[i].dec, 0, 0, 0);
         chk($sformatf("kat %0d", i), cap_key[kat[i].round - 1], kat[i].exp);
         post_done();
      end

      // Backpressure at round 5 for 3 cycles
      start_key(64'h133457799BBCDFF1, 1'b0);
      collect(64'h133457799BBCDFF1, 1'b0, 5, 3, 0);
      chk("backpressure round1", cap_key[0], 48'h1B02EFFC7072);
      chk("backpressure round16", cap_key[15], 48'hCB3D8B0E17F5);
      post_done();

      // Random keys, directions and stalls
      for (int i = 0; i < 8; i++) begin
         rk = {$urandom, $urandom};
         rd = 1'($urandom_range(0, 1));
         start_key(rk, rd);
         collect(rk, rd, $urandom_range(1, 16), $urandom_range(0, 3), 0);
         post_done();
      end

      // Reset at round_idx 7, then a fresh key
      start_key(64'h0E329232EA6D0D73, 1'b0);
      subkey_ready = 1'b1;
      c = 0;
      while (!(subkey_valid && round_idx == 5'd7) && c < 40) begin
         @(posedge clock); #1; c++;
      end
      chk("reached round 7", round_idx, 7);
      reset_n = 1'b0;
      #1;
      chk("mid reset key_ready", key_ready, 1);
      chk("mid reset subkey_valid", subkey_valid, 0);
      chk("mid reset round_idx", round_idx, 0);
      chk("mid reset subkey_out", subkey_out, 0);
      chk("mid reset sched_done", sched_done, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      chk("key_ready after reset", key_ready, 1);
      chk("no resume after reset", subkey_valid, 0);
      start_key(64'hAABB09182736CCDD, 1'b0);
      chk("fresh key round1", subkey_out, model_subkey(64'hAABB09182736CCDD, 1));
      collect(64'hAABB09182736CCDD, 1'b0, 0, 0, 0);

      // key_valid during RUN ignored; key held from DONE accepted one cycle later
      post_done();
      start_key(64'h0123456789ABCDEF, 1'b0);
      collect(64'h0123456789ABCDEF, 1'b0, 0, 0, 4);
      key_valid = 1'b1; key_in = 64'hFEDCBA9876543210; decrypt = 1'b1;
      @(posedge clock); #1;
      chk("held key not taken in DONE", subkey_valid, 0);
      chk("key_ready cycle after done", key_ready, 1);
      chk("sched_done cleared", sched_done, 0);
      @(posedge clock); #1;
      key_valid = 1'b0;
      chk("held key accepted", subkey_valid, 1);
      chk("held key round_idx", round_idx, 1);
      collect(64'hFEDCBA9876543210, 1'b1, 0, 0, 0);
      post_done();

      // Parity flags
      start_key(64'h0101010101010101, 1'b0);
      collect(64'h0101010101010101, 1'b0, 0, 0, 0);
      post_done();
      start_key(64'h0001010101010101, 1'b0);
      collect(64'h0001010101010101, 1'b0, 0, 0, 0);
      post_done();
      chk("parity_err holds after schedule", parity_err, par_model(64'h0001010101010101));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
